// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns: one column per cycle, 4-cycle latency, valid/ready handshakes.
// Define MIX_COLUMNS_SEQ_INV_EN to build the inverse column unit and honour inv_i.

module mix_col_fwd (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a [4];
  logic [7:0] x [4];
  logic [7:0] b [4];

  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      a[r] = col_i[31-8*r -: 8];
      x[r] = xt(a[r]);
    end
    for (int unsigned r = 0; r < 4; r++) begin
      b[r] = x[r] ^ x[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    col_o = {b[0], b[1], b[2], b[3]};
  end
endmodule

module mix_col_inv (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a  [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  logic [7:0] b  [4];

  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      logic [7:0] x2, x4, x8;
      a[r]  = col_i[31-8*r -: 8];
      x2    = xt(a[r]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int unsigned r = 0; r < 4; r++) begin
      b[r] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    col_o = {b[0], b[1], b[2], b[3]};
  end
endmodule

module mix_columns_seq #(
  parameter int unsigned BYTE0_MSB = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] state_i,
  input  logic         inv_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] state_o,
  output logic         busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] in_q, in_d;
  logic [127:0] out_q, out_d;
  logic [7:0]   in_bytes [16];
  logic [31:0]  col_in, fwd_res, col_res;

`ifdef MIX_COLUMNS_SEQ_INV_EN
  logic         inv_q, inv_d;
  logic [31:0]  inv_res;

  mix_col_inv u_inv (.col_i(col_in), .col_o(inv_res));
`else
  logic         unused_inv;
  assign unused_inv = inv_i;
`endif

  mix_col_fwd u_fwd (.col_i(col_in), .col_o(fwd_res));

  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      if (BYTE0_MSB != 0) in_bytes[k] = in_q[127-8*k -: 8];
      else                in_bytes[k] = in_q[8*k +: 8];
    end
    col_in = {in_bytes[{col_cnt_q, 2'd0}], in_bytes[{col_cnt_q, 2'd1}],
              in_bytes[{col_cnt_q, 2'd2}], in_bytes[{col_cnt_q, 2'd3}]};
`ifdef MIX_COLUMNS_SEQ_INV_EN
    col_res = inv_q ? inv_res : fwd_res;
`else
    col_res = fwd_res;
`endif
  end

  always_comb begin
    fsm_d     = fsm_q;
    col_cnt_d = col_cnt_q;
    in_d      = in_q;
    out_d     = out_q;
`ifdef MIX_COLUMNS_SEQ_INV_EN
    inv_d     = inv_q;
`endif
    unique case (fsm_q)
      IDLE: begin
        if (in_valid_i) begin
          in_d      = state_i;
`ifdef MIX_COLUMNS_SEQ_INV_EN
          inv_d     = inv_i;
`endif
          col_cnt_d = '0;
          fsm_d     = RUN;
        end
      end
      RUN: begin
        // Only the 4 bytes of the current column are overwritten; the rest hold.
        for (int unsigned k = 0; k < 16; k++) begin
          logic [3:0] kk;
          kk = 4'(k);
          if (kk[3:2] == col_cnt_q) begin
            if (BYTE0_MSB != 0) out_d[127-8*k -: 8] = col_res[31-8*kk[1:0] -: 8];
            else                out_d[8*k +: 8]     = col_res[31-8*kk[1:0] -: 8];
          end
        end
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) fsm_d = DONE;
      end
      DONE: begin
        if (out_ready_i) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= IDLE;
      col_cnt_q <= '0;
      in_q      <= '0;
      out_q     <= '0;
`ifdef MIX_COLUMNS_SEQ_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      col_cnt_q <= col_cnt_d;
      in_q      <= in_d;
      out_q     <= out_d;
`ifdef MIX_COLUMNS_SEQ_INV_EN
      inv_q     <= inv_d;
`endif
    end
  end

  assign in_ready_o  = (fsm_q == IDLE);
  assign out_valid_o = (fsm_q == DONE);
  assign busy_o      = (fsm_q != IDLE);
  assign state_o     = out_q;
endmodule

// File: tb/tb_mix_columns_seq.sv
// Randomised self-checking bench for mix_columns_seq against a GF(2^8) matrix reference model.
module tb_mix_columns_seq;
`ifdef MIX_COLUMNS_SEQ_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, in_valid_i, inv_i, out_ready_i;
  logic         in_ready_o, out_valid_o, busy_o;
  logic [127:0] state_i, state_o;
  int unsigned  cyc = 0;
  int unsigned  n_checks = 0;
  int unsigned  n_pass = 0;

  localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] VEC_F = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;

  always #5 clk = ~clk;

  mix_columns_seq #(.BYTE0_MSB(1)) dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .state_i(state_i), .inv_i(inv_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .state_o(state_o), .busy_o(busy_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] p;
    logic [7:0] r;
    r = 8'h00;
    p = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p[7:0];
      p = p << 1;
      if (p[8]) p = p ^ 9'h11b;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0] coef [4];
    logic [7:0] acc;
    logic [127:0] o;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - r + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_block(input logic [127:0] d, input logic iv, input int unsigned delay,
                           output logic [127:0] res, output int lat);
    int guard = 0;
    while (!in_ready_o && guard < 20) begin step(); guard++; end
    in_valid_i = 1'b1; state_i = d; inv_i = iv;
    step();
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 20) begin step(); lat++; end
    res = state_o;
    repeat (delay) step();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid_i = 1'b1; state_i = VEC_A; inv_i = 1'b0; out_ready_i = 1'b0;
    step(); step();
    reset = 1'b0; in_valid_i = 1'b0;
    n_checks++;
    if ({in_ready_o, out_valid_o, busy_o} !== 3'b100)
      $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100", {in_ready_o, out_valid_o, busy_o});
    else n_pass++;
    n_checks++;
    if (state_o !== 128'h0) $display("FAIL reset_state: got %h expected 0", state_o);
    else n_pass++;
  endtask

  task automatic test_forward_vector();
    logic [127:0] res;
    int lat;
    run_block(VEC_A, 1'b0, 0, res, lat);
    n_checks++;
    if (lat !== 4) $display("FAIL fwd_latency: got %0d expected 4", lat);
    else n_pass++;
    n_checks++;
    if (res !== VEC_F) $display("FAIL fwd_vector: got %h expected %h", res, VEC_F);
    else n_pass++;
    n_checks++;
    if ({in_ready_o, busy_o} !== 2'b10)
      $display("FAIL fwd_idle_after: got rdy/busy=%b expected 10", {in_ready_o, busy_o});
    else n_pass++;
  endtask

  task automatic test_inverse_select();
    logic [127:0] res, exp_v;
    int lat;
    run_block(VEC_F, 1'b1, 1, res, lat);
    exp_v = INV_EN ? VEC_A : ref_mix(VEC_F, 1'b0);
    n_checks++;
    if (res !== exp_v) $display("FAIL inv_vector: got %h expected %h", res, exp_v);
    else n_pass++;
    run_block(VEC_A, 1'b1, 0, res, lat);
    exp_v = INV_EN ? ref_mix(VEC_A, 1'b1) : VEC_F;
    n_checks++;
    if (res !== exp_v) $display("FAIL inv_ignored_or_applied: got %h expected %h", res, exp_v);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [127:0] d, res, exp_v;
    logic iv;
    int lat;
    for (int i = 0; i < 16; i++) begin
      d = rnd128();
      iv = 1'($urandom_range(0, 1));
      run_block(d, iv, $urandom_range(0, 3), res, lat);
      exp_v = ref_mix(d, INV_EN && iv);
      n_checks++;
      if (lat !== 4 || res !== exp_v)
        $display("FAIL random_%0d: got lat=%0d %h expected lat=4 %h", i, lat, res, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    int lat = 0;
    in_valid_i = 1'b1; state_i = VEC_A; inv_i = 1'b0; out_ready_i = 1'b0;
    step();
    in_valid_i = 1'b0;
    while (!out_valid_o && lat < 20) begin step(); lat++; end
    held = state_o;
    n_checks++;
    if (held !== VEC_F) $display("FAIL bp_result: got %h expected %h", held, VEC_F);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; state_i = rnd128();
      n_checks++;
      if (in_ready_o !== 1'b0) $display("FAIL bp_ready_%0d: got %b expected 0", i, in_ready_o);
      else n_pass++;
      step();
      n_checks++;
      if (out_valid_o !== 1'b1 || state_o !== VEC_F)
        $display("FAIL bp_hold_%0d: got vld=%b %h expected vld=1 %h", i, out_valid_o, state_o, VEC_F);
      else n_pass++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    n_checks++;
    if ({in_ready_o, out_valid_o, busy_o} !== 3'b100 || state_o !== VEC_F)
      $display("FAIL bp_release: got rdy/vld/busy=%b %h expected 100 %h",
               {in_ready_o, out_valid_o, busy_o}, state_o, VEC_F);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    in_valid_i = 1'b1; state_i = rnd128(); inv_i = 1'b0; out_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({in_ready_o, out_valid_o, busy_o} !== 3'b100 || state_o !== 128'h0)
      $display("FAIL rst_mid_run: got rdy/vld/busy=%b %h expected 100 0",
               {in_ready_o, out_valid_o, busy_o}, state_o);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (out_valid_o) seen++;
      step();
    end
    out_ready_i = 1'b0;
    n_checks++;
    if (seen !== 0) $display("FAIL rst_no_result: got %0d valid cycles expected 0", seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] b_in, b_exp;
    int unsigned acc [$];
    logic [127:0] res [$];
    logic [63:0] top;
    b_in = {64'hc6c6c6c6_d4d4d4d5, $urandom, $urandom};
    b_exp = ref_mix(b_in, 1'b0);
    in_valid_i = 1'b1; state_i = VEC_A; inv_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 40 && res.size() < 2; i++) begin
      if (out_valid_o) res.push_back(state_o);
      if (in_valid_i && in_ready_o) acc.push_back(cyc);
      step();
      if (acc.size() == 1) state_i = b_in;
      if (acc.size() == 2) in_valid_i = 1'b0;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    n_checks++;
    if (acc.size() != 2 || acc[1] - acc[0] != 6)
      $display("FAIL b2b_spacing: got %0d accepts gap %0d expected 2 gap 6",
               acc.size(), (acc.size() == 2) ? acc[1] - acc[0] : 0);
    else n_pass++;
    n_checks++;
    if (res.size() != 2) $display("FAIL b2b_results: got %0d expected 2", res.size());
    else begin
      top = res[1][127:64];
      if (res[0] !== VEC_F || res[1] !== b_exp || top !== 64'hc6c6c6c6_d5d5d7d6)
        $display("FAIL b2b_data: got %h %h expected %h %h", res[0], res[1], VEC_F, b_exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_forward_vector();
    test_inverse_select();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
